// File: rtl/quicksort_host.sv
// quicksort_host: loads one streamed frame into a `quicksort` block through its
// toggle-command interface (clear, push per word, sort, pop until empty) and
// streams the sorted words back out.
module quicksort_host #(
  parameter int unsigned W      = 16,
  parameter int unsigned CW     = 8,
  parameter int unsigned SETTLE = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          enable,
  input  logic [W-1:0]  s_data,
  input  logic          s_valid,
  input  logic          s_last,
  output logic          s_ready,
  output logic [W-1:0]  m_data,
  output logic          m_valid,
  output logic          m_last,
  input  logic          m_ready,
  output logic          q_clear,
  output logic          q_push,
  output logic          q_sort,
  output logic          q_pop,
  output logic [W-1:0]  q_rx_data,
  input  logic [W-1:0]  q_tx_data,
  input  logic          q_full,
  input  logic          q_empty,
  input  logic          q_idle,
  output logic          busy,
  output logic          overflow,
  output logic [CW-1:0] count
);

  localparam int unsigned SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

  // Gray-coded so that every legal transition flips one bit where possible.
  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StClear  = 3'b001,
    StLoad   = 3'b011,
    StPush   = 3'b010,
    StSort   = 3'b110,
    StUnload = 3'b111,
    StPop    = 3'b101,
    StWait   = 3'b100
  } state_e;

  state_e        state_q, state_d, ret_q, ret_d;
  logic [SW-1:0] wait_q, wait_d;
  logic          clear_q, clear_d, push_q, push_d, sort_q, sort_d, pop_q, pop_d;
  logic [W-1:0]  rx_data_q, rx_data_d, m_data_q, m_data_d;
  logic          last_q, last_d, drop_q, drop_d;
  logic          m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic          busy_q, busy_d, overflow_q, overflow_d;
  logic [CW-1:0] count_q, count_d, rem_q, rem_d;
  logic          hs_in;

  assign hs_in = s_valid & s_ready;

  // State register: current state, return state after WAIT, settle counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      ret_q   <= StIdle;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic; every command state parks in WAIT until the queue settles.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    wait_d  = wait_q;
    unique case (state_q)
      StIdle:   if (enable && s_valid) state_d = StClear;
      StClear:  begin state_d = StWait; ret_d = StLoad; wait_d = SW'(SETTLE); end
      StLoad: begin
        if (drop_q) begin
          if (hs_in && s_last) state_d = StSort;
        end else if (hs_in) begin
          state_d = StPush;
        end
      end
      StPush: begin
        state_d = StWait;
        ret_d   = last_q ? StSort : StLoad;
        wait_d  = SW'(SETTLE);
      end
      StSort:   begin state_d = StWait; ret_d = StUnload; wait_d = SW'(SETTLE); end
      StUnload: begin
        if (!m_valid_q) begin
          if (q_empty) state_d = StIdle;
        end else if (m_ready) begin
          state_d = StPop;
        end
      end
      StPop:    begin state_d = StWait; ret_d = StUnload; wait_d = SW'(SETTLE); end
      StWait: begin
        if (wait_q != '0) wait_d = wait_q - 1'b1;
        else if (q_idle)  state_d = ret_q;
      end
      default:  state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  // Datapath next-state: toggles, latched word, counters, output beat.
  always_comb begin
    clear_d    = clear_q;
    push_d     = push_q;
    sort_d     = sort_q;
    pop_d      = pop_q;
    rx_data_d  = rx_data_q;
    last_d     = last_q;
    drop_d     = drop_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    m_last_d   = m_last_q;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    count_d    = count_q;
    rem_d      = rem_q;
    unique case (state_q)
      StIdle: begin
        if (enable && s_valid) begin
          count_d    = '0;
          overflow_d = 1'b0;
          busy_d     = 1'b1;
          drop_d     = 1'b0;
        end
      end
      StClear: clear_d = ~clear_q;
      StLoad: begin
        if (!drop_q) begin
          if (hs_in) begin
            rx_data_d = s_data;
            last_d    = s_last;
          end else if (s_valid && q_full) begin
            // Queue is full: flag it and swallow the rest of the frame.
            overflow_d = 1'b1;
            drop_d     = 1'b1;
          end
        end
      end
      StPush: begin
        push_d = ~push_q;
        if (count_q != '1) count_d = count_q + 1'b1;
      end
      StSort: begin
        sort_d = ~sort_q;
        rem_d  = count_q;
      end
      StUnload: begin
        if (!m_valid_q) begin
          if (q_empty) begin
            busy_d = 1'b0;
          end else begin
            m_data_d  = q_tx_data;
            m_valid_d = 1'b1;
            m_last_d  = (rem_q == CW'(1));
          end
        end else if (m_ready) begin
          m_valid_d = 1'b0;
          m_last_d  = 1'b0;
        end
      end
      StPop: begin
        pop_d = ~pop_q;
        if (rem_q != '0) rem_d = rem_q - 1'b1;
      end
      default: ;
    endcase
    // Abort: keep toggle levels, overflow and count; drop the frame.
    if (!enable) begin
      clear_d    = clear_q;
      push_d     = push_q;
      sort_d     = sort_q;
      pop_d      = pop_q;
      overflow_d = overflow_q;
      count_d    = count_q;
      busy_d     = 1'b0;
      m_valid_d  = 1'b0;
      m_last_d   = 1'b0;
      drop_d     = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clear_q    <= 1'b0;
      push_q     <= 1'b0;
      sort_q     <= 1'b0;
      pop_q      <= 1'b0;
      rx_data_q  <= '0;
      last_q     <= 1'b0;
      drop_q     <= 1'b0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
      count_q    <= '0;
      rem_q      <= '0;
    end else begin
      clear_q    <= clear_d;
      push_q     <= push_d;
      sort_q     <= sort_d;
      pop_q      <= pop_d;
      rx_data_q  <= rx_data_d;
      last_q     <= last_d;
      drop_q     <= drop_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      m_last_q   <= m_last_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
      count_q    <= count_d;
      rem_q      <= rem_d;
    end
  end

  // Outputs; stream handshakes are gated by enable so they drop at once.
  always_comb begin
    s_ready   = enable && (state_q == StLoad) && (drop_q || (q_idle && !q_full));
    m_valid   = enable && m_valid_q;
    m_last    = enable && m_valid_q && m_last_q;
    m_data    = m_data_q;
    q_clear   = clear_q;
    q_push    = push_q;
    q_sort    = sort_q;
    q_pop     = pop_q;
    q_rx_data = rx_data_q;
    busy      = busy_q;
    overflow  = overflow_q;
    count     = count_q;
  end

endmodule
